// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch PC sequencer.
// Build option: PC_COMPRESSED_EN enables 2-byte instructions (+2 step, halfword targets).
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } pc_state_e;

  typedef enum logic [2:0] {
    SEL_SEQ      = 3'd0,
    SEL_BRANCH   = 3'd1,
    SEL_JAL      = 3'd2,
    SEL_JALR     = 3'd3,
    SEL_REDIRECT = 3'd4,
    SEL_TRAP     = 3'd5,
    SEL_HOLD     = 3'd6
  } pc_sel_e;

  localparam int INSTR_BYTES = 4;

`ifdef PC_COMPRESSED_EN
  localparam int INSTR_BYTES_C = 2;
  // Halfword alignment is legal, so only bit 0 marks a bad target.
  localparam int MISALIGN_BIT  = 0;
`else
  // Word alignment required; bit 1 set means the target straddles a word.
  localparam int MISALIGN_BIT  = 1;
`endif

endpackage

// File: rtl/pc_target_gen.sv
// Control-transfer target generation for the fetch PC sequencer.
// Build option: PC_COMPRESSED_EN (through pc_pkg) relaxes the alignment check.
module pc_target_gen
  import pc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] src1_value,
  input  logic [XLEN-1:0] imm_value,
  output logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] jal_target,
  output logic [XLEN-1:0] jalr_target,
  output logic            branch_misaligned,
  output logic            jal_misaligned,
  output logic            jalr_misaligned
);

  // PC-relative and register-relative targets, all modulo 2^XLEN.
  always_comb begin
    branch_target     = pc + imm_value;
    jal_target        = pc + imm_value;
    jalr_target       = (src1_value + imm_value) & ~XLEN'(1);
    branch_misaligned = branch_target[MISALIGN_BIT];
    jal_misaligned    = jal_target[MISALIGN_BIT];
    jalr_misaligned   = jalr_target[MISALIGN_BIT];
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: boot/run/trap FSM, redirect/stall/jump priority,
// misaligned-target trapping with exception PC capture.
// Build option: PC_COMPRESSED_EN adds is_compressed (+2 sequential step).
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic [XLEN-1:0] src1_value,
  input  logic [XLEN-1:0] imm_value,
  input  logic            is_branch,
  input  logic            is_jump,
  input  logic            is_jalr,
`ifdef PC_COMPRESSED_EN
  input  logic            is_compressed,
`endif
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            pc_valid,
  output logic            misalign_exc,
  output logic [XLEN-1:0] epc
);

  pc_state_e       state;
  pc_state_e       state_next;
  pc_sel_e         sel;
  logic [XLEN-1:0] incr;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] jal_target;
  logic [XLEN-1:0] jalr_target;
  logic            branch_misaligned;
  logic            jal_misaligned;
  logic            jalr_misaligned;

  pc_target_gen #(
    .XLEN (XLEN)
  ) u_target_gen (
    .pc                (pc),
    .src1_value        (src1_value),
    .imm_value         (imm_value),
    .branch_target     (branch_target),
    .jal_target        (jal_target),
    .jalr_target       (jalr_target),
    .branch_misaligned (branch_misaligned),
    .jal_misaligned    (jal_misaligned),
    .jalr_misaligned   (jalr_misaligned)
  );

  // Sequential step size; also defines the link value.
  always_comb begin
`ifdef PC_COMPRESSED_EN
    incr = is_compressed ? XLEN'(INSTR_BYTES_C) : XLEN'(INSTR_BYTES);
`else
    incr = XLEN'(INSTR_BYTES);
`endif
    pc_plus4 = pc + incr;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: BOOT lasts one cycle, a bad target enters TRAP, TRAP leaves unless held.
  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = RUN;
      RUN:     if (sel == SEL_TRAP) state_next = TRAP;
      TRAP:    if (sel != SEL_HOLD) state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  // Outputs: fetch-valid flag and next-PC source selection by priority.
  always_comb begin
    pc_valid = (state != BOOT);
    sel      = SEL_HOLD;
    case (state)
      RUN: begin
        if (redirect_valid)  sel = SEL_REDIRECT;
        else if (stall)      sel = SEL_HOLD;
        else if (is_jalr)    sel = jalr_misaligned   ? SEL_TRAP : SEL_JALR;
        else if (is_jump)    sel = jal_misaligned    ? SEL_TRAP : SEL_JAL;
        else if (is_branch)  sel = branch_misaligned ? SEL_TRAP : SEL_BRANCH;
        else                 sel = SEL_SEQ;
      end
      TRAP: begin
        // The trap handler's first fetch just steps forward; flushes still win.
        if (redirect_valid)  sel = SEL_REDIRECT;
        else if (stall)      sel = SEL_HOLD;
        else                 sel = SEL_SEQ;
      end
      default: sel = SEL_HOLD;
    endcase
  end

  // PC, exception PC and the single-cycle trap pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc           <= RESET_VECTOR;
      epc          <= '0;
      misalign_exc <= 1'b0;
    end else begin
      misalign_exc <= (sel == SEL_TRAP);
      case (sel)
        SEL_SEQ:      pc <= pc_plus4;
        SEL_BRANCH:   pc <= branch_target;
        SEL_JAL:      pc <= jal_target;
        SEL_JALR:     pc <= jalr_target;
        SEL_REDIRECT: pc <= redirect_pc;
        SEL_TRAP: begin
          pc  <= TRAP_VECTOR;
          epc <= pc;
        end
        default:      pc <= pc;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios then random traffic,
// checked against a behavioural model of the fetch-PC rules.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid, is_branch, is_jump, is_jalr;
  logic [31:0] redirect_pc, src1_value, imm_value;
  logic        is_compressed;
  logic [31:0] pc, pc_plus4, epc;
  logic        pc_valid, misalign_exc;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .src1_value     (src1_value),
    .imm_value      (imm_value),
    .is_branch      (is_branch),
    .is_jump        (is_jump),
    .is_jalr        (is_jalr),
`ifdef PC_COMPRESSED_EN
    .is_compressed  (is_compressed),
`endif
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .pc_valid       (pc_valid),
    .misalign_exc   (misalign_exc),
    .epc            (epc)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pcp4;
    logic [31:0] epc;
    logic        valid;
    logic        exc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model state: phase 0 = booting, 1 = running, 2 = just trapped.
  int          m_phase = 0;
  logic [31:0] m_pc    = RV;
  logic [31:0] m_epc   = '0;
  logic        m_exc   = 1'b0;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endfunction

  function automatic int step_bytes(logic cmp);
`ifdef PC_COMPRESSED_EN
    return cmp ? 2 : 4;
`else
    return 4;
`endif
  endfunction

  function automatic logic bad_target(logic [31:0] t);
`ifdef PC_COMPRESSED_EN
    return t[0];
`else
    return t[1];
`endif
  endfunction

  // Drive one cycle of inputs, advance the model, queue the expected outputs.
  task automatic apply(input logic rst, input logic stl, input logic rdv,
                       input logic [31:0] rpc, input logic [31:0] s1,
                       input logic [31:0] imm, input logic br, input logic jp,
                       input logic jr, input logic cmp);
    logic [31:0] t;
    logic        have;
    exp_t        e;
    reset = rst; stall = stl; redirect_valid = rdv; redirect_pc = rpc;
    src1_value = s1; imm_value = imm; is_branch = br; is_jump = jp;
    is_jalr = jr; is_compressed = cmp;
    if (rst) begin
      m_phase = 0; m_pc = RV; m_epc = '0; m_exc = 1'b0;
    end else if (m_phase == 0) begin
      m_phase = 1; m_exc = 1'b0;
    end else begin
      m_exc = 1'b0;
      if (rdv) begin
        m_pc = rpc; m_phase = 1;
      end else if (stl) begin
        // everything held
      end else if (m_phase == 2) begin
        m_pc = m_pc + step_bytes(cmp); m_phase = 1;
      end else begin
        have = 1'b1;
        t    = '0;
        if (jr)      t = (s1 + imm) & 32'hFFFF_FFFE;
        else if (jp) t = m_pc + imm;
        else if (br) t = m_pc + imm;
        else         have = 1'b0;
        if (have && bad_target(t)) begin
          m_epc = m_pc; m_pc = TV; m_exc = 1'b1; m_phase = 2;
        end else if (have) begin
          m_pc = t;
        end else begin
          m_pc = m_pc + step_bytes(cmp);
        end
      end
    end
    e.pc    = m_pc;
    e.pcp4  = m_pc + step_bytes(cmp);
    e.epc   = m_epc;
    e.valid = (m_phase != 0);
    e.exc   = m_exc;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input logic cmp);
    apply(0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, cmp);
  endtask

  task automatic redir(input logic [31:0] target);
    apply(0, 0, 1, target, 32'h0, 32'h0, 0, 0, 0, 0);
  endtask

  // Monitor: compare every presented output sample against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        cyc++;
        chk("pc", pc, e.pc);
        chk("pc_plus4", pc_plus4, e.pcp4);
        chk("pc_valid", 32'(pc_valid), 32'(e.valid));
        chk("misalign_exc", 32'(misalign_exc), 32'(e.exc));
        chk("epc", epc, e.epc);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        rs, st, rd, br, jp, jr, cm;
    logic [31:0] rp, s1, im;

    // Reset held two cycles, then boot and sequential run.
    apply(1, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
    apply(1, 1, 1, 32'h40, 32'h0, 32'h0, 1, 1, 1, 0);
    idle(0); idle(0); idle(0); idle(0);

    // Branch and JALR together: JALR wins; then branch alone.
    redir(32'h10);
    apply(0, 0, 0, 32'h0, 32'h100, 32'h8, 1, 0, 1, 0);
    apply(0, 0, 0, 32'h0, 32'h100, 32'h8, 1, 0, 0, 0);

    // Stall freezes the PC; redirect overrides stall.
    apply(0, 1, 0, 32'h0, 32'h0, 32'h0, 0, 1, 0, 0);
    apply(0, 1, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
    apply(0, 1, 0, 32'h0, 32'h0, 32'h0, 1, 0, 0, 0);
    apply(0, 1, 1, 32'h400, 32'h0, 32'h0, 0, 0, 0, 0);

    // Misaligned JAL traps, pulse lasts one cycle, then sequential.
    redir(32'h20);
    apply(0, 0, 0, 32'h0, 32'h0, 32'h6, 0, 1, 0, 0);
    idle(0); idle(0);

    // Misaligned JALR, with a stall while trapped.
    apply(0, 0, 0, 32'h0, 32'h1000, 32'h2, 0, 0, 1, 0);
    apply(0, 1, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
    idle(0);

    // Wrap-around at the top of the address space.
    redir(32'hFFFF_FFFC);
    idle(0);

    // Reset in the middle of activity beats redirect and stall.
    apply(0, 0, 0, 32'h0, 32'h0, 32'h6, 0, 1, 0, 0);
    apply(1, 1, 1, 32'h800, 32'h0, 32'h0, 0, 0, 0, 0);
    idle(0); idle(0);

`ifdef PC_COMPRESSED_EN
    // Compressed step and a halfword-aligned JAL.
    redir(32'h0);
    apply(0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 1);
    apply(0, 0, 0, 32'h0, 32'h0, 32'h6, 0, 1, 0, 0);
    idle(1);
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rs = ($urandom_range(0, 63) == 0);
      st = ($urandom_range(0, 5) == 0);
      rd = ($urandom_range(0, 9) == 0);
      br = ($urandom_range(0, 3) == 0);
      jp = ($urandom_range(0, 3) == 0);
      jr = ($urandom_range(0, 3) == 0);
      cm = ($urandom_range(0, 2) == 0);
`ifdef PC_COMPRESSED_EN
      rp = $urandom() & 32'hFFFF_FFFE;
`else
      rp = $urandom() & 32'hFFFF_FFFC;
`endif
      s1 = $urandom();
      if ($urandom_range(0, 1) == 0) im = $urandom_range(0, 255) & 32'hFFFF_FFFE;
      else                           im = $urandom() & 32'hFFFF_FFFE;
      apply(rs, st, rd, rp, s1, im, br, jp, jr, cm);
    end
    idle(0);

    @(posedge clk);
    #3;
    chk("drain", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised successor to the single-width `program_counter`.
- Generates the fetch PC for the RISC-V core and sits between decode/execute redirect logic and instruction fetch.
- Adds the following over the previous block:
  - configurable XLEN and reset/trap vectors
  - stall handling
  - JALR targets
  - external redirect
  - misaligned-target trapping with an exception PC
  - a boot/run/trap state machine

Parameters:
- XLEN, 32, datapath and PC width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on a misaligned-target exception.

Ports:
- clk  input  1  core clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold PC; no update this cycle.
- redirect_valid  input  1  external redirect (trap return, flush).
- redirect_pc  input  XLEN  external redirect target.
- src1_value  input  XLEN  rs1 value, used for JALR.
- imm_value  input  XLEN  sign-extended immediate.
- is_branch  input  1  taken conditional branch; target = pc + imm_value.
- is_jump  input  1  JAL; target = pc + imm_value.
- is_jalr  input  1  JALR; target = (src1_value + imm_value) & ~1.
- pc  output  XLEN  current fetch PC.
- pc_plus4  output  XLEN  pc + 4, the link value for JAL/JALR.
- pc_valid  output  1  pc holds a fetchable address.
- misalign_exc  output  1  one-cycle pulse on a misaligned-target trap.
- epc  output  XLEN  PC of the instruction that caused the last trap.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values:
  - pc = RESET_VECTOR, pc_valid = 0, misalign_exc = 0, epc = 0.
  - State goes to BOOT.
- State machine (pc_state_e):
  - BOOT: pc_valid = 0. Moves unconditionally to RUN on the next edge; pc stays RESET_VECTOR. The first valid fetch is therefore the 2nd cycle after reset deasserts.
  - RUN: pc_valid = 1. pc updates each edge per the priority list below.
  - TRAP: entered when the selected target is misaligned.
    - On that edge: pc <= TRAP_VECTOR, epc <= current pc, misalign_exc = 1 for exactly one cycle.
    - pc_valid = 1 in TRAP.
    - The next edge returns to RUN with sequential update (pc + 4). Stall holds TRAP.
- Next-PC priority in RUN, highest first:
  1. reset
  2. redirect_valid (ignores stall; the flush wins)
  3. stall
  4. is_jalr
  5. is_jump
  6. is_branch
  7. sequential pc + 4
- Multiple control inputs asserted together: the highest-priority one wins; the others are ignored silently.
- Misalignment:
  - Checked only on is_jalr/is_jump/is_branch targets.
  - Misaligned means target[1] = 1; target[0] is always zero for JALR and cannot occur for branches.
  - redirect_pc is trusted and loaded as given.
  - The misaligned target is never loaded into pc.
- Arithmetic: all additions are modulo 2^XLEN, with no overflow detection. pc = {XLEN{1}} - 3 followed by sequential update wraps to 0.
- Outputs: pc is registered. pc_plus4 is combinational from pc. Latency from a control input to the pc change is 1 cycle.
- Reset mid-operation: reset overrides every input, including stall and redirect. misalign_exc is cleared on the same edge.

Optional Feature:
- Macro: PC_COMPRESSED_EN.
- Defined:
  - Adds input `is_compressed` (1 bit). The sequential increment is +2 when is_compressed = 1, otherwise +4.
  - pc_plus4 becomes the link address: pc + 2 or pc + 4 accordingly.
  - Only target[0] is checked for misalignment, so 2-byte-aligned targets are legal.
- Undefined:
  - No is_compressed port; the increment is always +4.
  - target[1] = 1 traps as described in Behaviour.

Decomposition:
- Shared package `pc_pkg`:
  - pc_state_e {BOOT, RUN, TRAP}
  - pc_sel_e {SEL_SEQ, SEL_BRANCH, SEL_JAL, SEL_JALR, SEL_REDIRECT, SEL_TRAP, SEL_HOLD}
  - localparam INSTR_BYTES = 4
- One natural sub-module, `pc_target_gen`: combinational. It computes the branch/JAL/JALR targets and the misalignment flag from pc, src1_value and imm_value.

Test Plan:
1. Reset then release: reset high 2 cycles, low → pc = 0, pc_valid = 0 for 1 cycle, then pc_valid = 1 and pc = 0, 4, 8 on successive edges.
2. Branch vs JALR priority: pc = 0x10, imm = 0x8, src1 = 0x100, is_branch = 1 and is_jalr = 1 → next pc = 0x108. Next, is_branch only, with pc = 0x108 → 0x110.
3. Stall vs redirect: stall = 1 for 3 cycles → pc frozen. Then stall = 1 with redirect_valid = 1 and redirect_pc = 0x400 → pc = 0x400 next edge.
4. Misaligned JAL: pc = 0x20, imm = 0x6, is_jump = 1 → pc = 0x100, epc = 0x20, misalign_exc high exactly 1 cycle, then pc = 0x104.
5. Wrap-around: redirect to 0xFFFF_FFFC, then sequential → pc = 0x0000_0000.
6. PC_COMPRESSED_EN build:
   - is_compressed = 1 from pc = 0x0 → 0x2.
   - JAL with imm = 0x6 from pc = 0x2 → pc = 0x8, no trap.
